uart_cfg_sequencer: RTL and testbench

Parametrised successor to the fixed-table UART master: transmits a programmable byte table to a downstream UART TX, with a timed inter-byte gap between bytes. Adds a runtime-writable table, runtime length, three modes (write-only, echo-verify with retry, continuous loop), response timeout, abort and error reporting. Sits between the board control logic (VIO or CPU register bank) and the uart_tx / uart_rx pair.

---
 rtl/uart_cfg_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_uart_cfg_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_sequencer.sv
// Programmable UART byte sequencer: sends a runtime-written table with a timed gap before every
// byte, with optional echo verification and retry, continuous looping, abort and error reporting.
module uart_cfg_sequencer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned GAP_CYCLES  = 5208,
  parameter int unsigned RSP_TIMEOUT = 100000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  tbl_we_i,
  input  logic [ADDR_WIDTH-1:0] tbl_addr_i,
  input  logic [DATA_WIDTH-1:0] tbl_wdata_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic [1:0]            mode_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  uart_tx_start_o,
  output logic [DATA_WIDTH-1:0] uart_data_tx_o,
  input  logic                  uart_tx_end_i,
  input  logic                  uart_rx_valid_i,
  input  logic [DATA_WIDTH-1:0] uart_rx_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [15:0]           pass_cnt_o
);

  typedef enum logic [3:0] {
    StIdle, StGap, StSend, StWaitTx, StWaitRx, StCheck, StNext, StDone, StError
  } state_e;

  localparam logic [ADDR_WIDTH:0] LenOne = 1;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] tbl [DEPTH];
  logic                  start_q1, start_q2;
  logic [ADDR_WIDTH:0]   len_q;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           gap_cnt_q, tmo_cnt_q, retry_q;
  logic [DATA_WIDTH-1:0] echo_q;
  logic                  echo_vld_q;

  logic                start_rise, gap_last, tmo_last, last_entry, echo_ok;
  logic [ADDR_WIDTH:0] len_clamped;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  assign start_rise  = start_q1 & ~start_q2;
  assign gap_last    = ({1'b0, gap_cnt_q} + 33'd1) >= 33'(GAP_CYCLES);
  assign tmo_last    = ({1'b0, tmo_cnt_q} + 33'd1) >= 33'(RSP_TIMEOUT);
  assign last_entry  = ({1'b0, addr_q} == (len_q - LenOne));
  assign echo_ok     = echo_vld_q && (echo_q == tbl[addr_q]);
  assign len_clamped = (32'(len_i) > DEPTH) ? (ADDR_WIDTH + 1)'(DEPTH) : len_i;

  // Table has no reset so its contents survive a mid-run reset.
  always_ff @(posedge clk_i) begin
    if (tbl_we_i && !busy_o && (32'(tbl_addr_i) < DEPTH)) begin
      tbl[tbl_addr_i] <= tbl_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= StIdle;
      start_q1        <= 1'b0;
      start_q2        <= 1'b0;
      len_q           <= '0;
      mode_q          <= '0;
      addr_q          <= '0;
      gap_cnt_q       <= '0;
      tmo_cnt_q       <= '0;
      retry_q         <= '0;
      echo_q          <= '0;
      echo_vld_q      <= 1'b0;
      uart_tx_start_o <= 1'b0;
      uart_data_tx_o  <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      err_addr_o      <= '0;
      pass_cnt_o      <= '0;
    end else begin
      start_q1        <= start_i;
      start_q2        <= start_q1;
      uart_tx_start_o <= 1'b0;
      done_o          <= 1'b0;

      // First echo after SEND wins; SEND itself handles a same-cycle byte.
      if ((state_q == StWaitTx || state_q == StWaitRx) && uart_rx_valid_i && !echo_vld_q) begin
        echo_q     <= uart_rx_data_i;
        echo_vld_q <= 1'b1;
      end

      if (abort_i && state_q != StIdle) begin
        state_q <= StIdle;
        busy_o  <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start_rise) begin
              len_q      <= len_clamped;
              mode_q     <= mode_i;
              err_o      <= 1'b0;
              err_addr_o <= '0;
              pass_cnt_o <= '0;
              addr_q     <= '0;
              retry_q    <= '0;
              gap_cnt_q  <= '0;
              busy_o     <= 1'b1;
              state_q    <= (len_i == '0) ? StDone : StGap;
            end
          end
          StGap: begin
            if (gap_last) state_q <= StSend;
            else gap_cnt_q <= sat_inc(gap_cnt_q);
          end
          StSend: begin
            uart_data_tx_o  <= tbl[addr_q];
            uart_tx_start_o <= 1'b1;
            echo_vld_q      <= uart_rx_valid_i;
            if (uart_rx_valid_i) echo_q <= uart_rx_data_i;
            state_q         <= StWaitTx;
          end
          StWaitTx: begin
            if (uart_tx_end_i) begin
              tmo_cnt_q <= '0;
              state_q   <= (mode_q == 2'd1) ? StWaitRx : StNext;
            end
          end
          StWaitRx: begin
            if (echo_vld_q || tmo_last) state_q <= StCheck;
            else tmo_cnt_q <= sat_inc(tmo_cnt_q);
          end
          StCheck: begin
            if (echo_ok) begin
              retry_q <= '0;
              state_q <= StNext;
            end else if (retry_q < 32'(MAX_RETRY)) begin
              retry_q   <= retry_q + 32'd1;
              gap_cnt_q <= '0;
              state_q   <= StGap;
            end else begin
              err_o      <= 1'b1;
              err_addr_o <= addr_q;
              state_q    <= StError;
            end
          end
          StNext: begin
            gap_cnt_q <= '0;
            if (!last_entry) begin
              addr_q  <= addr_q + 1'b1;
              state_q <= StGap;
            end else if (mode_q == 2'd2) begin
              addr_q     <= '0;
              pass_cnt_o <= pass_cnt_o + 16'd1;
              state_q    <= StGap;
            end else begin
              state_q <= StDone;
            end
          end
          StDone: begin
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            state_q <= StIdle;
          end
          StError: begin
            busy_o  <= 1'b0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// Directed bench for uart_cfg_sequencer with a UART TX/RX echo model driven on the falling edge.
module tb_uart_cfg_sequencer;

  localparam int GAP = 8;
  localparam int TMO = 20;
  localparam int TXLAT = 10;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       tbl_we_i = 1'b0;
  logic [4:0] tbl_addr_i = '0;
  logic [7:0] tbl_wdata_i = '0;
  logic [5:0] len_i = '0;
  logic [1:0] mode_i = '0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       uart_tx_start_o;
  logic [7:0] uart_data_tx_o;
  logic       uart_tx_end_i = 1'b0;
  logic       uart_rx_valid_i = 1'b0;
  logic [7:0] uart_rx_data_i = '0;
  logic       busy_o, done_o, err_o;
  logic [4:0] err_addr_o;
  logic [15:0] pass_cnt_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Model state
  int         cyc = 0, last_evt = 0, min_gap = 1000, done_cnt = 0;
  int         tx_cnt = 0, rx_cnt = 0;
  int         echo_mode = 0;  // 0 no echo, 1 echo, 2 echo 0x00 for echo_bad
  logic [7:0] echo_bad = 8'h00;
  logic [7:0] last_data = 8'h00;
  logic [7:0] sent_q[$];
  int         tx_cyc_q[$];

  uart_cfg_sequencer #(
    .DATA_WIDTH(8), .DEPTH(32), .ADDR_WIDTH(5),
    .GAP_CYCLES(GAP), .RSP_TIMEOUT(TMO), .MAX_RETRY(3)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .tbl_we_i(tbl_we_i), .tbl_addr_i(tbl_addr_i), .tbl_wdata_i(tbl_wdata_i),
    .len_i(len_i), .mode_i(mode_i), .start_i(start_i), .abort_i(abort_i),
    .uart_tx_start_o(uart_tx_start_o), .uart_data_tx_o(uart_data_tx_o),
    .uart_tx_end_i(uart_tx_end_i), .uart_rx_valid_i(uart_rx_valid_i),
    .uart_rx_data_i(uart_rx_data_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_addr_o(err_addr_o),
    .pass_cnt_o(pass_cnt_o)
  );

  always #5 clk = ~clk;

  // UART TX/RX model: tx_end TXLAT cycles after each start, optional echo 2 cycles later.
  initial begin
    int gap;
    forever begin
      @(negedge clk);
      cyc++;
      uart_tx_end_i   = 1'b0;
      uart_rx_valid_i = 1'b0;
      if (reset_i) begin
        tx_cnt = 0;
        rx_cnt = 0;
      end else begin
        if (rx_cnt > 0) begin
          rx_cnt--;
          if (rx_cnt == 0) begin
            uart_rx_valid_i = 1'b1;
            uart_rx_data_i  = (echo_mode == 2 && last_data == echo_bad) ? 8'h00 : last_data;
          end
        end
        if (uart_tx_start_o) begin
          sent_q.push_back(uart_data_tx_o);
          tx_cyc_q.push_back(cyc);
          gap = cyc - last_evt - 1;
          if (gap < min_gap) min_gap = gap;
          tx_cnt    = TXLAT;
          last_data = uart_data_tx_o;
        end else if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) begin
            uart_tx_end_i = 1'b1;
            last_evt      = cyc;
            if (echo_mode != 0) rx_cnt = 2;
          end
        end
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic write_tbl(input int addr, input logic [7:0] data);
    @(negedge clk);
    tbl_we_i = 1'b1; tbl_addr_i = 5'(addr); tbl_wdata_i = data;
    @(negedge clk);
    tbl_we_i = 1'b0;
  endtask

  task automatic launch(input int len, input int mode);
    @(negedge clk);
    sent_q.delete(); tx_cyc_q.delete();
    done_cnt = 0; min_gap = 1000; last_evt = cyc;
    len_i = 6'(len); mode_i = 2'(mode); start_i = 1'b1;
    repeat (3) @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy_o !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    vec_cnt++;
    if (busy_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_idle: busy still %b after %0d cycles, need 0", name, busy_o, budget);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({busy_o, done_o, err_o, uart_tx_start_o} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_flags: got %b need 0000", {busy_o, done_o, err_o, uart_tx_start_o});
    end
    vec_cnt++;
    if ({err_addr_o, pass_cnt_o, uart_data_tx_o} !== 29'd0) begin
      err_cnt++;
      $display("FAIL reset_values: got %h need 0", {err_addr_o, pass_cnt_o, uart_data_tx_o});
    end
  endtask

  task automatic test_write_only();
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) write_tbl(i, exp[i]);
    launch(4, 0);
    wait_idle(1000, "wo");
    vec_cnt++;
    if (sent_q.size() != 4) begin
      err_cnt++;
      $display("FAIL wo_count: got %0d bytes need 4", sent_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vec_cnt++;
        if (sent_q[i] !== exp[i]) begin
          err_cnt++;
          $display("FAIL wo_data%0d: got %h need %h", i, sent_q[i], exp[i]);
        end
      end
    end
    vec_cnt++;
    if (min_gap < GAP) begin
      err_cnt++;
      $display("FAIL wo_gap: got %0d idle cycles need >= %0d", min_gap, GAP);
    end
    vec_cnt++;
    if (done_cnt != 1 || err_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL wo_done: got done=%0d err=%b need 1/0", done_cnt, err_o);
    end
  endtask

  task automatic test_echo_ok();
    echo_mode = 1;
    launch(2, 1);
    wait_idle(1000, "echo_ok");
    vec_cnt++;
    if (sent_q.size() != 2 || done_cnt != 1 || err_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL echo_ok: got sends=%0d done=%0d err=%b need 2/1/0",
               sent_q.size(), done_cnt, err_o);
    end
  endtask

  task automatic test_echo_bad();
    int n22 = 0;
    echo_mode = 2;
    echo_bad  = 8'h22;
    launch(2, 1);
    wait_idle(2000, "echo_bad");
    foreach (sent_q[i]) if (sent_q[i] == 8'h22) n22++;
    vec_cnt++;
    if (sent_q.size() != 5 || n22 != 4) begin
      err_cnt++;
      $display("FAIL echo_bad_sends: got total=%0d entry1=%0d need 5/4", sent_q.size(), n22);
    end
    vec_cnt++;
    if (err_o !== 1'b1 || err_addr_o !== 5'd1 || done_cnt != 0) begin
      err_cnt++;
      $display("FAIL echo_bad_err: got err=%b addr=%0d done=%0d need 1/1/0",
               err_o, err_addr_o, done_cnt);
    end
  endtask

  task automatic test_timeout();
    int exp_int = TXLAT + TMO + GAP + 3;
    echo_mode = 0;
    launch(2, 1);
    wait_idle(2000, "tmo");
    vec_cnt++;
    if (sent_q.size() != 4 || sent_q[0] !== 8'h11 || sent_q[3] !== 8'h11) begin
      err_cnt++;
      $display("FAIL tmo_sends: got %0d sends need 4 of 11", sent_q.size());
    end
    vec_cnt++;
    if (tx_cyc_q.size() < 2 || (tx_cyc_q[1] - tx_cyc_q[0]) != exp_int) begin
      err_cnt++;
      $display("FAIL tmo_interval: got %0d cycles need %0d",
               (tx_cyc_q.size() < 2) ? -1 : tx_cyc_q[1] - tx_cyc_q[0], exp_int);
    end
    vec_cnt++;
    if (err_o !== 1'b1 || err_addr_o !== 5'd0 || done_cnt != 0) begin
      err_cnt++;
      $display("FAIL tmo_err: got err=%b addr=%0d done=%0d need 1/0/0",
               err_o, err_addr_o, done_cnt);
    end
  endtask

  task automatic test_loop();
    logic [7:0] exp [6] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33};
    int n = 0;
    int bad = 0;
    echo_mode = 0;
    launch(3, 2);
    while (sent_q.size() < 6 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (14) @(negedge clk);
    vec_cnt++;
    if (pass_cnt_o !== 16'd2 || err_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL loop_pass: got pass=%0d err=%b need 2/0", pass_cnt_o, err_o);
    end
    for (int i = 0; i < 6; i++) if (i >= sent_q.size() || sent_q[i] !== exp[i]) bad++;
    vec_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL loop_order: got %0d wrong of 6 need 0", bad);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    vec_cnt++;
    if (busy_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_busy: got %b need 0", busy_o);
    end
    repeat (40) @(negedge clk);
    vec_cnt++;
    if (sent_q.size() != 6 || done_cnt != 0) begin
      err_cnt++;
      $display("FAIL abort_quiet: got sends=%0d done=%0d need 6/0", sent_q.size(), done_cnt);
    end
  endtask

  task automatic test_len0();
    @(negedge clk);
    sent_q.delete();
    len_i = 6'd0; mode_i = 2'd0; start_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vec_cnt++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL len0_launch: got busy=%b done=%b need 1/0", busy_o, done_o);
    end
    @(negedge clk);
    vec_cnt++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL len0_done: got done=%b busy=%b need 1/0", done_o, busy_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    vec_cnt++;
    if (done_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL len0_pulse: got done=%b need 0", done_o);
    end
    repeat (20) @(negedge clk);
    vec_cnt++;
    if (sent_q.size() != 0) begin
      err_cnt++;
      $display("FAIL len0_notx: got %0d sends need 0", sent_q.size());
    end
  endtask

  task automatic test_clamp_lock();
    int bad = 0;
    for (int i = 0; i < 32; i++) write_tbl(i, 8'(i * 7 + 3));
    launch(40, 0);
    write_tbl(0, 8'hEE);
    wait_idle(3000, "clamp");
    for (int i = 0; i < 32; i++) if (i >= sent_q.size() || sent_q[i] !== 8'(i * 7 + 3)) bad++;
    vec_cnt++;
    if (sent_q.size() != 32 || bad != 0) begin
      err_cnt++;
      $display("FAIL clamp: got %0d sends %0d wrong need 32/0", sent_q.size(), bad);
    end
    launch(1, 0);
    wait_idle(500, "lock");
    vec_cnt++;
    if (sent_q.size() != 1 || sent_q[0] !== 8'h03) begin
      err_cnt++;
      $display("FAIL write_lock: got n=%0d byte=%h need 1/03", sent_q.size(),
               (sent_q.size() > 0) ? sent_q[0] : 8'hxx);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    launch(4, 0);
    while (sent_q.size() < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({busy_o, done_o, err_o, uart_tx_start_o, uart_data_tx_o, pass_cnt_o} !== 28'd0) begin
      err_cnt++;
      $display("FAIL reset_mid: got busy=%b data=%h need all 0", busy_o, uart_data_tx_o);
    end
    @(negedge clk);
    reset_i = 1'b0;
    repeat (20) @(negedge clk);
    launch(2, 0);
    wait_idle(500, "rerun");
    vec_cnt++;
    if (sent_q.size() != 2 || sent_q[0] !== 8'h03 || sent_q[1] !== 8'h0A) begin
      err_cnt++;
      $display("FAIL rerun_table: got n=%0d need 2 bytes 03 0a", sent_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_only();
    test_echo_ok();
    test_echo_bad();
    test_timeout();
    test_loop();
    test_len0();
    test_clamp_lock();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
